// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcodes, control-word layout, control and
// immediate decode, and source-register usage.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  // Field order fixes the bit positions: alu_src is bit 9, alu_op is [1:0].
  typedef struct packed {
    logic       alu_src;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic int rw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_R:      begin c.reg_write = 1'b1; c.alu_op = ALUOP_R; end
      OP_IMM:    begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALUOP_I; end
      OP_LOAD:   begin
        c.alu_src = 1'b1; c.mem_to_reg = WB_MEM; c.reg_write = 1'b1; c.mem_read = 1'b1;
      end
      OP_STORE:  begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
      OP_BRANCH: begin c.branch = 1'b1; c.alu_op = ALUOP_BR; end
      OP_JAL:    begin c.mem_to_reg = WB_PC4; c.reg_write = 1'b1; c.jump = 1'b1; end
      OP_JALR:   begin
        c.alu_src = 1'b1; c.mem_to_reg = WB_PC4; c.reg_write = 1'b1; c.jump = 1'b1;
      end
      OP_LUI:    begin c.alu_src = 1'b1; c.mem_to_reg = WB_IMM; c.reg_write = 1'b1; end
      OP_AUIPC:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALUOP_ADD; end
      default:   ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] i);
    case (i[6:0])
      OP_IMM, OP_LOAD, OP_JALR: return {{20{i[31]}}, i[31:20]};
      OP_STORE:                 return {{20{i[31]}}, i[31:25], i[11:7]};
      OP_BRANCH:                return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         return {i[31:12], 12'b0};
      OP_JAL:                   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:                  return '0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R || op == OP_STORE || op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/regfile_bp.sv
// NREG x XLEN register file, two combinational read ports, one write port,
// x0 hard-wired to zero, optional WB write-through on reads.
module regfile_bp import riscv_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int WB_BYPASS = 1,
  localparam int RW       = rw_f(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [RW-1:0]        wa,
  input  logic [XLEN-1:0]      wd,
  input  logic [1:0][RW-1:0]   ra,
  output logic [1:0][XLEN-1:0] rdata
);

  logic [NREG-1:0][XLEN-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we && wa != '0) mem_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    assign rdata[p] = (ra[p] == '0) ? '0 :
                      ((WB_BYPASS != 0) && we && wa == ra[p]) ? wd : mem_q[ra[p]];
  end

endmodule

// File: rtl/id_stage_hz.sv
// Decode stage: regfile read, imm/control decode, load-use bubble insertion
// and the ID/EX pipeline register with flush and EX back-pressure.
module id_stage_hz import riscv_pkg::*; #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int LU_BUBBLES = 1,
  parameter int WB_BYPASS  = 1,
  localparam int RW        = rw_f(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr_ifid,
  input  logic [XLEN-1:0] pc_ifid,
  input  logic [XLEN-1:0] pc4_ifid,
  input  logic            valid_ifid,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush_id,
  input  logic            hold_ex,
  output logic            stall_if,
  output logic            valid_idex,
  output logic [XLEN-1:0] rs1_data_idex,
  output logic [XLEN-1:0] rs2_data_idex,
  output logic [XLEN-1:0] imm_idex,
  output logic [XLEN-1:0] pc_idex,
  output logic [XLEN-1:0] pc4_idex,
  output logic [31:0]     instr_idex,
  output logic [RW-1:0]   rs1_idex,
  output logic [RW-1:0]   rs2_idex,
  output logic [RW-1:0]   rd_idex,
  output logic [9:0]      ctrl_idex
);

  localparam int CW = (LU_BUBBLES > 1) ? $clog2(LU_BUBBLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LU_BUBBLES - 1);

  typedef struct packed {
    logic            valid;
    ctrl_t           ctrl;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [31:0]     instr;
  } idex_t;

  logic [6:0]            op;
  logic [RW-1:0]         rs1, rs2, rd;
  logic [1:0][RW-1:0]    rf_ra;
  logic [1:0][XLEN-1:0]  rf_rdata;
  idex_t                 idex_q, idex_d, dec;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  hazard, bubble;

  assign op    = instr_ifid[6:0];
  assign rs1   = instr_ifid[15 +: RW];
  assign rs2   = instr_ifid[20 +: RW];
  assign rd    = instr_ifid[7 +: RW];
  assign rf_ra = {rs2, rs1};

  regfile_bp #(.XLEN(XLEN), .NREG(NREG), .WB_BYPASS(WB_BYPASS)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wb_we),
    .wa    (wb_rd),
    .wd    (wb_data),
    .ra    (rf_ra),
    .rdata (rf_rdata)
  );

  // Load in EX whose destination is a live source of the instruction in ID.
  always_comb begin
    hazard = idex_q.valid && idex_q.ctrl.mem_read && (idex_q.rd != '0) && valid_ifid &&
             ((uses_rs1(op) && rs1 == idex_q.rd) || (uses_rs2(op) && rs2 == idex_q.rd));
    bubble = hazard || (cnt_q != '0);
  end

  assign stall_if = !flush_id && (bubble || hold_ex);

  always_comb begin
    dec          = '0;
    dec.valid    = valid_ifid;
    dec.ctrl     = valid_ifid ? decode_ctrl(op) : '0;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = rd;
    dec.rs1_data = rf_rdata[0];
    dec.rs2_data = rf_rdata[1];
    dec.imm      = XLEN'($signed(imm_gen(instr_ifid)));
    dec.pc       = pc_ifid;
    dec.pc4      = pc4_ifid;
    dec.instr    = instr_ifid;
  end

  // Flush wins over hold and hazard; hold freezes both ID/EX and the counter.
  always_comb begin
    idex_d = idex_q;
    cnt_d  = cnt_q;
    if (flush_id) begin
      idex_d = '0;
      cnt_d  = '0;
    end else if (!hold_ex) begin
      idex_d = dec;
      if (bubble) begin
        idex_d.valid = 1'b0;
        idex_d.ctrl  = '0;
        idex_d.rd    = '0;
      end
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else if (hazard) cnt_d = CNT_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_idex    = idex_q.valid;
  assign ctrl_idex     = idex_q.ctrl;
  assign rs1_idex      = idex_q.rs1;
  assign rs2_idex      = idex_q.rs2;
  assign rd_idex       = idex_q.rd;
  assign rs1_data_idex = idex_q.rs1_data;
  assign rs2_data_idex = idex_q.rs2_data;
  assign imm_idex      = idex_q.imm;
  assign pc_idex       = idex_q.pc;
  assign pc4_idex      = idex_q.pc4;
  assign instr_idex    = idex_q.instr;

endmodule

// File: tb/tb_id_stage_hz.sv
// Two decode stages (LU_BUBBLES=1 and 3) driven in lockstep and checked every
// cycle against an instruction-level model, plus directed literal scenarios.
module tb_id_stage_hz;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_ifid, pc_ifid, pc4_ifid, wb_data;
  logic        valid_ifid, wb_we, flush_id, hold_ex;
  logic [4:0]  wb_rd;

  logic        o_stall [2];
  logic        o_valid [2];
  logic [31:0] o_rs1d [2], o_rs2d [2], o_imm [2], o_pc [2], o_pc4 [2], o_instr [2];
  logic [4:0]  o_rs1 [2], o_rs2 [2], o_rd [2];
  logic [9:0]  o_ctrl [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_stage_hz #(.XLEN(32), .NREG(32), .LU_BUBBLES(g == 0 ? 1 : 3), .WB_BYPASS(1)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_ifid    (instr_ifid),
      .pc_ifid       (pc_ifid),
      .pc4_ifid      (pc4_ifid),
      .valid_ifid    (valid_ifid),
      .wb_we         (wb_we),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .flush_id      (flush_id),
      .hold_ex       (hold_ex),
      .stall_if      (o_stall[g]),
      .valid_idex    (o_valid[g]),
      .rs1_data_idex (o_rs1d[g]),
      .rs2_data_idex (o_rs2d[g]),
      .imm_idex      (o_imm[g]),
      .pc_idex       (o_pc[g]),
      .pc4_idex      (o_pc4[g]),
      .instr_idex    (o_instr[g]),
      .rs1_idex      (o_rs1[g]),
      .rs2_idex      (o_rs2[g]),
      .rd_idex       (o_rd[g]),
      .ctrl_idex     (o_ctrl[g])
    );
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit        v;
    bit [9:0]  c;
    bit [4:0]  rs1, rs2, rd;
    bit [31:0] d1, d2, imm, pc, pc4, ins;
  } mrec_t;

  mrec_t     m [2];
  int        left [2];
  bit [31:0] rf [32];
  bit        lu_t;
  mrec_t     nxt;

  function automatic int lub(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit [9:0] ref_ctrl(input bit [6:0] op);
    case (op)
      7'h33:   return 10'b0_00_1_0_0_0_0_10;
      7'h13:   return 10'b1_00_1_0_0_0_0_11;
      7'h03:   return 10'b1_01_1_1_0_0_0_00;
      7'h23:   return 10'b1_00_0_0_1_0_0_00;
      7'h63:   return 10'b0_00_0_0_0_1_0_01;
      7'h6F:   return 10'b0_10_1_0_0_0_1_00;
      7'h67:   return 10'b1_10_1_0_0_0_1_00;
      7'h37:   return 10'b1_11_1_0_0_0_0_00;
      7'h17:   return 10'b1_00_1_0_0_0_0_00;
      default: return 10'b0;
    endcase
  endfunction

  function automatic bit [31:0] ref_imm(input bit [31:0] i);
    int s;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: s = int'($signed(i[31:20]));
      7'h23:               s = int'($signed({i[31:25], i[11:7]}));
      7'h63:               s = int'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      7'h37, 7'h17:        s = int'({i[31:12], 12'h000});
      7'h6F:               s = int'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default:             s = 0;
    endcase
    return 32'(s);
  endfunction

  function automatic bit reads_reg(input bit [31:0] i, input bit [4:0] r);
    bit [6:0] op = i[6:0];
    bit u1 = !(op inside {7'h37, 7'h17, 7'h6F});
    bit u2 = op inside {7'h33, 7'h23, 7'h63};
    return (u1 && i[19:15] == r) || (u2 && i[24:20] == r);
  endfunction

  function automatic bit [31:0] rd_ref(input bit [4:0] a);
    if (a == 0) return 0;
    if (wb_we && wb_rd == a) return wb_data;
    return rf[a];
  endfunction

  function automatic bit load_use(input int k);
    return m[k].v && m[k].c[5] && m[k].rd != 0 && valid_ifid && reads_reg(instr_ifid, m[k].rd);
  endfunction

  function automatic bit exp_stall(input int k);
    return !flush_id && (load_use(k) || left[k] > 0 || hold_ex);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m[k]    = '{default: 0};
        left[k] = 0;
      end
      for (int i = 0; i < 32; i++) rf[i] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (flush_id) begin
          m[k]    = '{default: 0};
          left[k] = 0;
        end else if (!hold_ex) begin
          lu_t     = load_use(k);
          nxt.v    = valid_ifid && !(lu_t || left[k] > 0);
          nxt.c    = nxt.v ? ref_ctrl(instr_ifid[6:0]) : 10'b0;
          nxt.rd   = nxt.v || (valid_ifid == 1'b0 && !(lu_t || left[k] > 0)) ? instr_ifid[11:7] : 5'd0;
          nxt.rs1  = instr_ifid[19:15];
          nxt.rs2  = instr_ifid[24:20];
          nxt.d1   = rd_ref(instr_ifid[19:15]);
          nxt.d2   = rd_ref(instr_ifid[24:20]);
          nxt.imm  = ref_imm(instr_ifid);
          nxt.pc   = pc_ifid;
          nxt.pc4  = pc4_ifid;
          nxt.ins  = instr_ifid;
          m[k]     = nxt;
          if (left[k] > 0) left[k] = left[k] - 1;
          else if (lu_t)   left[k] = lub(k) - 1;
        end
      end
      if (wb_we && wb_rd != 0) rf[wb_rd] = wb_data;
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("stall_if",   k, 32'(o_stall[k]), 32'(exp_stall(k)));
      chk("valid_idex", k, 32'(o_valid[k]), 32'(m[k].v));
      chk("ctrl_idex",  k, 32'(o_ctrl[k]),  32'(m[k].c));
      chk("rd_idex",    k, 32'(o_rd[k]),    32'(m[k].rd));
      chk("rs1_idex",   k, 32'(o_rs1[k]),   32'(m[k].rs1));
      chk("rs2_idex",   k, 32'(o_rs2[k]),   32'(m[k].rs2));
      chk("rs1_data",   k, o_rs1d[k],       m[k].d1);
      chk("rs2_data",   k, o_rs2d[k],       m[k].d2);
      chk("imm_idex",   k, o_imm[k],        m[k].imm);
      chk("pc_idex",    k, o_pc[k],         m[k].pc);
      chk("pc4_idex",   k, o_pc4[k],        m[k].pc4);
      chk("instr_idex", k, o_instr[k],      m[k].ins);
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] LW5     = 32'h0000A283; // lw  x5,0(x1)
  localparam logic [31:0] LW0     = 32'h0000A003; // lw  x0,0(x1)
  localparam logic [31:0] ADD6    = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] ADD6_X0 = 32'h00200333; // add x6,x0,x2
  localparam logic [31:0] LUI5    = 32'h000012B7; // lui x5,1
  localparam logic [31:0] ADD8_X7 = 32'h00038433; // add x8,x7,x0

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v);
    instr_ifid = ins;
    valid_ifid = v;
    pc_ifid    = $urandom & 32'hFFFF_FFFC;
    pc4_ifid   = pc_ifid + 32'd4;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63,
                              7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    logic [31:0] r = $urandom;
    r[6:0]   = ops[$urandom_range(0, 10)];
    r[19:18] = 2'b0;
    r[24:23] = 2'b0;
    r[11:10] = 2'b0;
    return r;
  endfunction

  bit st1 [5] = '{1, 0, 0, 0, 0};
  bit st3 [5] = '{1, 1, 1, 0, 0};
  bit vd1 [5] = '{0, 1, 1, 1, 1};
  bit vd3 [5] = '{0, 0, 0, 1, 1};

  initial begin
    rst_n = 1'b0; instr_ifid = '0; pc_ifid = '0; pc4_ifid = '0; valid_ifid = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; flush_id = 1'b0; hold_ex = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, 32'(o_valid[k]), 32'd0);
      chk("rst_stall", k, 32'(o_stall[k]), 32'd0);
      chk("rst_pc",    k, o_pc[k],         32'd0);
    end
    rst_n = 1'b1;

    // Load-use pair: one bubble for LU=1, three for LU=3.
    drive(LW5, 1'b1); tick();
    for (int k = 0; k < 2; k++) chk("t1_lw_ctrl", k, 32'(o_ctrl[k]), 32'h2E0);
    drive(ADD6, 1'b1); #1;
    for (int i = 0; i < 5; i++) begin
      chk("t12_stall", 0, 32'(o_stall[0]), 32'(st1[i]));
      chk("t12_stall", 1, 32'(o_stall[1]), 32'(st3[i]));
      tick();
      chk("t12_valid", 0, 32'(o_valid[0]), 32'(vd1[i]));
      chk("t12_valid", 1, 32'(o_valid[1]), 32'(vd3[i]));
      chk("t12_ctrl",  1, 32'(o_ctrl[1]),  vd3[i] ? 32'h042 : 32'h0);
      #1;
    end

    // x0 destination and unused rs1 never stall.
    drive(LW0, 1'b1); tick();
    drive(ADD6_X0, 1'b1); #1;
    for (int k = 0; k < 2; k++) chk("t3_x0_stall", k, 32'(o_stall[k]), 32'd0);
    drive(LW5, 1'b1); tick();
    drive(LUI5, 1'b1); #1;
    for (int k = 0; k < 2; k++) chk("t3_lui_stall", k, 32'(o_stall[k]), 32'd0);
    tick();

    // Same-cycle WB write-through, then the stored value.
    drive(ADD8_X7, 1'b1);
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("t4_bypass", k, o_rs1d[k], 32'hDEADBEEF);
      chk("t4_rd",     k, 32'(o_rd[k]), 32'd8);
    end
    wb_we = 1'b0; wb_data = 32'h0;
    tick();
    for (int k = 0; k < 2; k++) chk("t4_stored", k, o_rs1d[k], 32'hDEADBEEF);

    // Flush beats a simultaneous hazard.
    drive(LW5, 1'b1); tick();
    drive(ADD6, 1'b1); flush_id = 1'b1; #1;
    for (int k = 0; k < 2; k++) chk("t5_stall", k, 32'(o_stall[k]), 32'd0);
    tick();
    flush_id = 1'b0; #1;
    for (int k = 0; k < 2; k++) begin
      chk("t5_valid", k, 32'(o_valid[k]), 32'd0);
      chk("t5_instr", k, o_instr[k],      32'd0);
      chk("t5_pc",    k, o_pc[k],         32'd0);
      chk("t5_stall_after", k, 32'(o_stall[k]), 32'd0);
    end

    // Hold during the LU=3 bubble sequence freezes it.
    drive(LW5, 1'b1); tick();
    drive(ADD6, 1'b1); tick();
    hold_ex = 1'b1; #1;
    for (int k = 0; k < 2; k++) chk("t6_stall_hold", k, 32'(o_stall[k]), 32'd1);
    repeat (2) begin
      tick();
      chk("t6_valid_hold", 1, 32'(o_valid[1]), 32'd0);
    end
    hold_ex = 1'b0; #1;
    chk("t6_stall_rel", 1, 32'(o_stall[1]), 32'd1);
    tick(); chk("t6_bub_a", 1, 32'(o_valid[1]), 32'd0);
    tick(); chk("t6_bub_b", 1, 32'(o_valid[1]), 32'd0);
    tick(); chk("t6_add",   1, 32'(o_valid[1]), 32'd1);

    // Async reset in the middle of a stall.
    drive(LW5, 1'b1); tick();
    drive(ADD6, 1'b1); tick();
    rst_n = 1'b0; #1;
    for (int k = 0; k < 2; k++) begin
      chk("t7_rst_valid", k, 32'(o_valid[k]), 32'd0);
      chk("t7_rst_stall", k, 32'(o_stall[k]), 32'd0);
    end
    tick();
    rst_n = 1'b1; #1;
    chk("t7_idle", 1, 32'(o_stall[1]), 32'd0);
    tick();
    chk("t7_add_valid", 1, 32'(o_valid[1]), 32'd1);
    chk("t7_add_ctrl",  1, 32'(o_ctrl[1]),  32'h042);

    // Random traffic with small register indices to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      drive(rand_instr(), $urandom_range(0, 9) != 0);
      wb_we    = ($urandom_range(0, 1) == 1);
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      flush_id = ($urandom_range(0, 9) == 0);
      hold_ex  = ($urandom_range(0, 6) == 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
